// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolution with mispredict flush and fetch redirect.
// Latency: res_*, flush and redir_* are registered and appear 1 cycle after acceptance.
// Backpressure: in_ready drops while a redirect waits for redir_ready; BR_PERF_CNT_EN adds perf counters.
module branch_resolve #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_kind,
    input  logic [WIDTH-1:0] in_pc,
    input  logic [WIDTH-1:0] in_imm,
    input  logic [WIDTH-1:0] in_rs1,
    input  logic             branch_taken,
    input  logic             pred_taken,
    input  logic [WIDTH-1:0] pred_target,
    output logic             res_valid,
    output logic             res_taken,
    output logic [WIDTH-1:0] res_link,
    output logic             res_mispredict,
    output logic             res_misalign,
    output logic             res_illegal,
    output logic             flush,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [WIDTH-1:0] redir_pc
`ifdef BR_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredicts
`endif
);

    localparam logic [1:0] KIND_BR   = 2'b00;
    localparam logic [1:0] KIND_JALR = 2'b10;
    localparam logic [1:0] KIND_RSVD = 2'b11;
    localparam logic [WIDTH-1:0] LSB_CLR = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic {
        IDLE,
        REDIRECT
    } state_t;

    state_t           state_q;
    state_t           state_n;

    logic             accept;
    logic             is_illegal;
    logic             actual_taken;
    logic [WIDTH-1:0] link_pc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] next_pc;
    logic             misalign;
    logic             raw_mispredict;
    logic             mispredict;

    // A new operation can only enter while no redirect is outstanding.
    assign accept = in_valid && (state_q == IDLE);

    // Resolve direction, target and mispredict for the operation on the inputs.
    always_comb begin
        is_illegal     = (in_kind == KIND_RSVD);
        link_pc        = in_pc + WIDTH'(4);
        if (in_kind == KIND_JALR) begin
            target = (in_rs1 + in_imm) & LSB_CLR;
        end else begin
            target = in_pc + in_imm;
        end
        // Reserved kinds are reported as not taken so nothing downstream acts on them.
        if (is_illegal) begin
            actual_taken = 1'b0;
        end else if (in_kind == KIND_BR) begin
            actual_taken = branch_taken;
        end else begin
            actual_taken = 1'b1;
        end
        next_pc        = actual_taken ? target : link_pc;
        misalign       = actual_taken && (target[1:0] != 2'b00);
        raw_mispredict = (actual_taken != pred_taken) ||
                         (actual_taken && (target != pred_target));
        // Misaligned targets are recovered by the trap path, not by a redirect.
        mispredict     = raw_mispredict && !misalign && !is_illegal;
    end

    // FSM state register; reset discards any pending redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // FSM next state and handshake outputs.
    always_comb begin
        state_n     = state_q;
        in_ready    = 1'b0;
        redir_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (accept && mispredict) begin
                    state_n = REDIRECT;
                end
            end
            REDIRECT: begin
                redir_valid = 1'b1;
                if (redir_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Result registers: pulse valid/flush per acceptance, hold res_* between acceptances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_link       <= '0;
            res_mispredict <= 1'b0;
            res_misalign   <= 1'b0;
            res_illegal    <= 1'b0;
            flush          <= 1'b0;
            redir_pc       <= '0;
        end else begin
            res_valid <= accept;
            flush     <= accept && mispredict;
            if (accept) begin
                res_taken      <= actual_taken;
                res_link       <= link_pc;
                res_mispredict <= mispredict;
                res_misalign   <= misalign;
                res_illegal    <= is_illegal;
            end
            // redir_pc only moves when a new redirect is launched, so it is stable while waiting.
            if (accept && mispredict) begin
                redir_pc <= next_pc;
            end
        end
    end

`ifdef BR_PERF_CNT_EN
    // Saturating performance counters for resolved branches and issued redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_branches    <= '0;
            cnt_mispredicts <= '0;
        end else begin
            if (accept && !is_illegal && (cnt_branches != {CNT_W{1'b1}})) begin
                cnt_branches <= cnt_branches + CNT_W'(1);
            end
            if (accept && mispredict && (cnt_mispredicts != {CNT_W{1'b1}})) begin
                cnt_mispredicts <= cnt_mispredicts + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed and randomized checks of branch_resolve against a behavioural model.
// Latency: model predicts outputs one cycle after each accepted operation; compared every negedge.
// Backpressure: redir_ready is driven directly in directed tests and randomly in the random phase.
module tb_branch_resolve;

    localparam int W  = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [1:0]    in_kind = '0;
    logic [W-1:0]  in_pc = '0;
    logic [W-1:0]  in_imm = '0;
    logic [W-1:0]  in_rs1 = '0;
    logic          branch_taken = 1'b0;
    logic          pred_taken = 1'b0;
    logic [W-1:0]  pred_target = '0;
    logic          res_valid;
    logic          res_taken;
    logic [W-1:0]  res_link;
    logic          res_mispredict;
    logic          res_misalign;
    logic          res_illegal;
    logic          flush;
    logic          redir_valid;
    logic          redir_ready = 1'b0;
    logic [W-1:0]  redir_pc;
`ifdef BR_PERF_CNT_EN
    logic [CW-1:0] cnt_branches;
    logic [CW-1:0] cnt_mispredicts;
`endif

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;
    bit rr_rand = 1'b0;

    // Model state
    bit           m_busy = 1'b0;
    bit           e_res_valid = 1'b0;
    bit           e_flush = 1'b0;
    bit           e_taken = 1'b0;
    bit           e_mp = 1'b0;
    bit           e_mis = 1'b0;
    bit           e_ill = 1'b0;
    logic [W-1:0] e_link = '0;
    logic [W-1:0] e_redir_pc = '0;
    int           m_br = 0;
    int           m_mp = 0;

    always #5 clk = ~clk;

    branch_resolve #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_kind        (in_kind),
        .in_pc          (in_pc),
        .in_imm         (in_imm),
        .in_rs1         (in_rs1),
        .branch_taken   (branch_taken),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .res_valid      (res_valid),
        .res_taken      (res_taken),
        .res_link       (res_link),
        .res_mispredict (res_mispredict),
        .res_misalign   (res_misalign),
        .res_illegal    (res_illegal),
        .flush          (flush),
        .redir_valid    (redir_valid),
        .redir_ready    (redir_ready),
        .redir_pc       (redir_pc)
`ifdef BR_PERF_CNT_EN
        ,
        .cnt_branches   (cnt_branches),
        .cnt_mispredicts(cnt_mispredicts)
`endif
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk64(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level evaluation of one operation.
    function automatic void ref_op(input logic [1:0] k, input logic [W-1:0] pc, input logic [W-1:0] imm,
                                   input logic [W-1:0] rs1, input logic bt, input logic pt,
                                   input logic [W-1:0] ptgt, output bit tk, output logic [W-1:0] npc,
                                   output bit mp, output bit mis, output bit ill);
        logic [W-1:0] tgt;
        ill = (k == 2'b11);
        tgt = (k == 2'b10) ? ((rs1 + imm) & ~64'd1) : (pc + imm);
        tk  = ill ? 1'b0 : ((k == 2'b00) ? bt : 1'b1);
        npc = tk ? tgt : pc + 64'd4;
        mis = tk && (tgt[1:0] != 2'b00);
        mp  = !ill && !mis && ((tk != pt) || (tk && (tgt != ptgt)));
    endfunction

    // Behavioural model: a busy flag for the outstanding redirect plus the last result.
    always @(posedge clk or negedge rst_n) begin : model
        bit acc;
        bit tk, mp, mis, ill;
        logic [W-1:0] npc;
        if (!rst_n) begin
            m_busy = 0; e_res_valid = 0; e_flush = 0; e_taken = 0; e_mp = 0;
            e_mis = 0; e_ill = 0; e_link = '0; e_redir_pc = '0; m_br = 0; m_mp = 0;
        end else begin
            acc = in_valid && !m_busy;
            if (m_busy && redir_ready) m_busy = 0;
            e_res_valid = acc;
            e_flush = 0;
            if (acc) begin
                ref_op(in_kind, in_pc, in_imm, in_rs1, branch_taken, pred_taken, pred_target,
                       tk, npc, mp, mis, ill);
                e_taken = tk; e_mp = mp; e_mis = mis; e_ill = ill; e_link = in_pc + 64'd4;
                if (mp) begin
                    e_flush = 1; m_busy = 1; e_redir_pc = npc;
                    if (m_mp < (1 << CW) - 1) m_mp++;
                end
                if (!ill && m_br < (1 << CW) - 1) m_br++;
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en && rst_n) begin
            chk1("in_ready", in_ready, !m_busy);
            chk1("redir_valid", redir_valid, m_busy);
            chk1("res_valid", res_valid, e_res_valid);
            chk1("flush", flush, e_flush);
            chk1("res_taken", res_taken, e_taken);
            chk1("res_mispredict", res_mispredict, e_mp);
            chk1("res_misalign", res_misalign, e_mis);
            chk1("res_illegal", res_illegal, e_ill);
            chk64("res_link", res_link, e_link);
            if (m_busy) chk64("redir_pc", redir_pc, e_redir_pc);
`ifdef BR_PERF_CNT_EN
            chk64("cnt_branches", 64'(cnt_branches), 64'(m_br));
            chk64("cnt_mispredicts", 64'(cnt_mispredicts), 64'(m_mp));
`endif
        end
    end

    always @(negedge clk) begin
        if (rr_rand) redir_ready = $urandom_range(0, 1) == 1;
    end

    // Present an operation at a negedge and return at the negedge after it is accepted.
    task automatic send(input logic [1:0] k, input logic [W-1:0] pc, input logic [W-1:0] imm,
                        input logic [W-1:0] rs1, input logic bt, input logic pt, input logic [W-1:0] ptgt);
        int n = 0;
        in_kind = k; in_pc = pc; in_imm = imm; in_rs1 = rs1;
        branch_taken = bt; pred_taken = pt; pred_target = ptgt;
        in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++; checks++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", n);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk1("rst_res_valid", res_valid, 1'b0);
        chk1("rst_flush", flush, 1'b0);
        chk1("rst_redir_valid", redir_valid, 1'b0);
        chk64("rst_redir_pc", redir_pc, 64'h0);
        chk64("rst_res_link", res_link, 64'h0);
        chk1("rst_res_taken", res_taken, 1'b0);
        chk1("rst_res_mispredict", res_mispredict, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk1("post_rst_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] pc, imm, rs1, ptgt;
        logic [1:0]   k;
        @(negedge clk);
        do_reset();
        cmp_en = 1'b1;

        // 1: correctly predicted taken BEQ
        send(2'b00, 64'h1000, 64'h40, 64'h0, 1'b1, 1'b1, 64'h1040);
        chk1("t1_res_valid", res_valid, 1'b1);
        chk1("t1_res_taken", res_taken, 1'b1);
        chk1("t1_mispredict", res_mispredict, 1'b0);
        chk1("t1_flush", flush, 1'b0);
        chk1("t1_redir_valid", redir_valid, 1'b0);
        @(negedge clk);
        chk1("t1_res_valid_pulse", res_valid, 1'b0);

        // 2: backward branch mispredicted not-taken, redirect held off 3 cycles
        redir_ready = 1'b0;
        send(2'b00, 64'h2000, -64'sd8, 64'h0, 1'b1, 1'b0, 64'h0);
        chk64("t2_model_redir_pc", e_redir_pc, 64'h1FF8);
        chk1("t2_flush", flush, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                chk1("t2_flush_once", flush, 1'b0);
            end
            chk1("t2_redir_valid", redir_valid, 1'b1);
            chk64("t2_redir_pc", redir_pc, 64'h1FF8);
            chk1("t2_in_ready_low", in_ready, 1'b0);
        end
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;
        chk1("t2_in_ready_back", in_ready, 1'b1);
        chk1("t2_redir_done", redir_valid, 1'b0);

        // 3: JALR with misaligned target (0x3012)
        send(2'b10, 64'h3000, 64'h10, 64'h3003, 1'b0, 1'b1, 64'h3010);
        chk1("t3_misalign", res_misalign, 1'b1);
        chk64("t3_link", res_link, 64'h3004);
        chk1("t3_mispredict", res_mispredict, 1'b0);
        chk1("t3_flush", flush, 1'b0);
        chk1("t3_redir_valid", redir_valid, 1'b0);

        // 4: JAL wrapping past the top of the address space
        send(2'b01, 64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 64'h0, 1'b0, 1'b0, 64'h0);
        chk64("t4_redir_pc", redir_pc, 64'h10);
        chk1("t4_mispredict", res_mispredict, 1'b1);
        chk64("t4_link", res_link, 64'hFFFF_FFFF_FFFF_FFF4);
        redir_ready = 1'b1;
        @(negedge clk);
        redir_ready = 1'b0;

        // 5: reset in the middle of a redirect, then a normal op and a reserved kind
        send(2'b00, 64'h4000, 64'h100, 64'h0, 1'b1, 1'b0, 64'h0);
        chk1("t5_redir_pending", redir_valid, 1'b1);
        do_reset();
        send(2'b01, 64'h5000, 64'h8, 64'h0, 1'b0, 1'b1, 64'h5008);
        chk1("t5_res_valid", res_valid, 1'b1);
        chk1("t5_mispredict", res_mispredict, 1'b0);
        chk1("t5_redir_valid", redir_valid, 1'b0);
        send(2'b11, 64'h6000, 64'h4, 64'h0, 1'b1, 1'b1, 64'h6004);
        chk1("t5_illegal", res_illegal, 1'b1);
        chk1("t5_ill_taken", res_taken, 1'b0);
        chk1("t5_ill_mispredict", res_mispredict, 1'b0);
        chk1("t5_ill_flush", flush, 1'b0);
        chk1("t5_ill_redir", redir_valid, 1'b0);

`ifdef BR_PERF_CNT_EN
        // 6: counters count then saturate (4-bit counters here)
        do_reset();
        redir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pc = 64'h8000 + 64'(i * 64);
            send(2'b00, pc, 64'h40, 64'h0, 1'b1, !(i == 2 || i == 5 || i == 8), pc + 64'h40);
        end
        @(negedge clk);
        chk64("t6_cnt_branches", 64'(cnt_branches), 64'd10);
        chk64("t6_cnt_mispredicts", 64'(cnt_mispredicts), 64'd3);
        for (int i = 0; i < 20; i++) begin
            send(2'b00, 64'h9000, 64'h40, 64'h0, 1'b0, 1'b0, 64'h0);
        end
        chk64("t6_cnt_saturate", 64'(cnt_branches), 64'd15);
        chk64("t6_cnt_mp_hold", 64'(cnt_mispredicts), 64'd3);
        redir_ready = 1'b0;
`endif

        // Randomized phase with random redirect backpressure and idle gaps.
        rr_rand = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            k   = 2'($urandom_range(0, 3));
            pc  = {$urandom, $urandom};
            imm = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($signed(12'($urandom)));
            rs1 = {$urandom, $urandom};
            if ($urandom_range(0, 7) != 0) begin
                pc[1:0] = 2'b00;
                imm[1:0] = 2'b00;
                rs1[1:0] = 2'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 3))
                0: ptgt = pc + imm;
                1: ptgt = (rs1 + imm) & ~64'd1;
                2: ptgt = pc + 64'd4;
                default: ptgt = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 3) == 0) begin
                in_kind = 2'($urandom); in_pc = {$urandom, $urandom}; branch_taken = $urandom_range(0, 1) == 1;
                @(negedge clk);
            end
            send(k, pc, imm, rs1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, ptgt);
        end
        rr_rand = 1'b0;
        redir_ready = 1'b1;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
